// File: rtl/avg_feeder_if.sv
// Sample stream from the producer into avg_feeder: valid/ready handshake
// carrying a 4-bit sample and an end-of-frame marker.
interface avg_feeder_if;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/avg_feeder.sv
// Front end for the 4-tap moving averager: buffers framed samples, paces loads,
// appends two zero flush loads per frame and emits only full-window sums.
module avg_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int INTERVAL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INTERVAL_W-1:0] cfg_interval,
    avg_feeder_if.slave           s,
    output logic                  avg_clr,
    output logic                  x_load,
    output logic [3:0]            x,
    input  logic [5:0]            y_in,
    output logic                  m_valid,
    output logic [5:0]            m_data,
    output logic                  m_last,
    output logic                  err_short,
    output logic                  busy
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0]  J_FULL     = 3'd5;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FLUSH} state_t;

    logic [4:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [4:0]    head;

    state_t                state_q, state_d;
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic [2:0]            j_q, j_d, j_inc;
    logic [1:0]            flush_cnt_q, flush_cnt_d;
    logic [3:0]            x_q, x_d;
    logic                  slot, last_load;

    logic       p1_valid_q, p1_last_q, p1_short_q;
    logic       m_valid_q, m_last_q, err_short_q;
    logic [5:0] m_data_q;

    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign s.s_ready  = !fifo_full;
    assign push       = s.s_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {s.s_last, s.s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A load slot is open whenever the interval counter has run down to zero.
    assign slot  = (cnt_q == '0);
    assign j_inc = (j_q == J_FULL) ? j_q : j_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = slot ? cnt_q : cnt_q - 1'b1;
        j_d         = j_q;
        flush_cnt_d = flush_cnt_q;
        x_d         = x_q;
        pop         = 1'b0;
        avg_clr     = 1'b0;
        x_load      = 1'b0;
        last_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = CLEAR;
            end
            CLEAR: begin
                avg_clr = 1'b1;
                j_d     = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (slot && !fifo_empty) begin
                    pop    = 1'b1;
                    x_load = 1'b1;
                    x_d    = head[3:0];
                    cnt_d  = cfg_interval;
                    j_d    = j_inc;
                    if (head[4]) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 2'd2;
                    end
                end
            end
            FLUSH: begin
                if (slot) begin
                    x_load      = 1'b1;
                    x_d         = '0;
                    cnt_d       = cfg_interval;
                    j_d         = j_inc;
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q == 2'd1) begin
                        last_load = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign x = x_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            j_q         <= '0;
            flush_cnt_q <= '0;
            x_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            flush_cnt_q <= flush_cnt_d;
            x_q         <= x_d;
        end
    end

    // y_in answers a load one cycle later; it is registered, so results land two cycles after the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            p1_short_q  <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            p1_valid_q  <= x_load && (j_q == J_FULL);
            p1_last_q   <= last_load;
            p1_short_q  <= last_load && (j_q != J_FULL);
            m_valid_q   <= p1_valid_q;
            m_data_q    <= p1_valid_q ? y_in : '0;
            m_last_q    <= p1_valid_q && p1_last_q;
            err_short_q <= p1_short_q;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign err_short = err_short_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_avg_feeder.sv
// Bench for avg_feeder: a behavioural averager drives y_in, and expected
// averages are the full-window sums of each frame, checked in arrival order.
module tb_avg_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cfg_interval = '0;
    logic       avg_clr, x_load;
    logic [3:0] x;
    logic [5:0] y_in = '0;
    logic       m_valid;
    logic [5:0] m_data;
    logic       m_last, err_short, busy;

    avg_feeder_if sif ();

    avg_feeder #(.FIFO_DEPTH(8), .INTERVAL_W(4)) dut (
        .clk(clk), .rst(rst), .cfg_interval(cfg_interval), .s(sif),
        .avg_clr(avg_clr), .x_load(x_load), .x(x), .y_in(y_in),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .err_short(err_short), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    int hist[$];
    int exp_q[$];
    int exp_ld[$];
    int ld_x[$], ld_cyc[$], clr_cyc[$];
    int pend_d[$], pend_l[$];
    int frame[$];
    int err_seen = 0, nr_cnt = 0;
    int exp_clr = 0, exp_err = 0;
    int ld_base = 0, clr_base = 0, err_base = 0, nr_base = 0;
    logic ld_d1 = 1'b0, ld_d2 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Averager model: y after load j is the sum of the samples loaded at j-5..j-2.
    function automatic int hist_window();
        int s = 0;
        int n = hist.size();
        for (int k = n - 6; k <= n - 3; k++)
            if (k >= 0) s += hist[k];
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst || avg_clr) begin
            hist.delete();
        end else if (x_load) begin
            hist.push_back(int'(x));
            y_in <= 6'(hist_window());
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("clr_load_exclusive", avg_clr & x_load, 0);
            if (avg_clr) clr_cyc.push_back(cyc);
            if (x_load) begin
                ld_x.push_back(int'(x));
                ld_cyc.push_back(cyc);
            end
            if (m_valid) begin
                check("m_valid_slot", ld_d2, 1);
                if (exp_q.size() == 0) begin
                    check("m_valid_unexpected", m_valid, 0);
                end else begin
                    check("m_data", m_data, exp_q[0] >> 1);
                    check("m_last", m_last, exp_q[0] & 1);
                    void'(exp_q.pop_front());
                end
            end
            if (err_short) begin
                err_seen <= err_seen + 1;
                check("err_short_slot", ld_d2, 1);
            end
            if (!sif.s_ready) nr_cnt <= nr_cnt + 1;
        end
        ld_d2 <= ld_d1;
        ld_d1 <= x_load && !rst;
    end

    task automatic push(input logic [3:0] d, input logic l);
        int n = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = l;
        while (!sif.s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", sif.s_ready, 1);
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic add_frame();
        int n = frame.size();
        for (int i = 0; i < n; i++) begin
            pend_d.push_back(frame[i]);
            pend_l.push_back(i == n - 1);
            exp_ld.push_back(frame[i]);
        end
        exp_ld.push_back(0);
        exp_ld.push_back(0);
        for (int i = 0; i + 3 < n; i++)
            exp_q.push_back((frame[i] + frame[i+1] + frame[i+2] + frame[i+3]) * 2 + ((i == n - 4) ? 1 : 0));
        if (n < 4) exp_err++;
        exp_clr++;
    endtask

    task automatic send_all(input int max_gap);
        while (pend_d.size() > 0) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            push(4'(pend_d.pop_front()), 1'(pend_l.pop_front()));
        end
    endtask

    task automatic start_check();
        ld_base  = ld_x.size();
        clr_base = clr_cyc.size();
        err_base = err_seen;
        nr_base  = nr_cnt;
        exp_ld.delete();
        exp_clr = 0;
        exp_err = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while (quiet < 6 && n < 5000) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic end_check(input int intv, input bit gapchk);
        wait_idle();
        check("outputs_drained", exp_q.size(), 0);
        check("load_count", ld_x.size() - ld_base, exp_ld.size());
        for (int i = 0; i < exp_ld.size() && ld_base + i < ld_x.size(); i++)
            check("load_x", ld_x[ld_base + i], exp_ld[i]);
        check("clear_count", clr_cyc.size() - clr_base, exp_clr);
        if (clr_cyc.size() > clr_base && ld_cyc.size() > ld_base)
            check("first_load_after_clear", ld_cyc[ld_base] - clr_cyc[clr_base], 1);
        if (gapchk)
            for (int i = ld_base + 1; i < ld_cyc.size(); i++)
                check("load_spacing", ld_cyc[i] - ld_cyc[i-1], intv + 1);
        check("err_short_count", err_seen - err_base, exp_err);
    endtask

    task automatic check_reset_state();
        check("rst_avg_clr", avg_clr, 0);
        check("rst_x_load", x_load, 0);
        check("rst_x", x, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_err_short", err_short, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", sif.s_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Test 1: single full window of fours.
        cfg_interval = 4'd0;
        start_check();
        frame = '{4, 4, 4, 4};
        add_frame();
        send_all(0);
        end_check(0, 1);

        // Test 2: ramp 0..7.
        start_check();
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back(i);
        add_frame();
        send_all(0);
        end_check(0, 1);

        // Test 3: maximum values with interval 2.
        cfg_interval = 4'd2;
        start_check();
        frame = '{15, 15, 15, 15, 15, 15};
        add_frame();
        send_all(0);
        end_check(2, 1);

        // Test 4: short frame, then a frame that must not see its residue.
        cfg_interval = 4'd0;
        start_check();
        frame = '{3, 5};
        add_frame();
        send_all(0);
        end_check(0, 1);
        start_check();
        frame = '{1, 1, 1, 1};
        add_frame();
        send_all(0);
        end_check(0, 1);

        // Test 5: FIFO fills under slow pacing, then a stalling producer.
        cfg_interval = 4'd3;
        start_check();
        frame.delete();
        for (int i = 0; i < 12; i++) frame.push_back($urandom_range(0, 15));
        add_frame();
        send_all(0);
        end_check(3, 1);
        check("fifo_full_seen", nr_cnt > nr_base, 1);
        cfg_interval = 4'd0;
        start_check();
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back($urandom_range(0, 15));
        add_frame();
        send_all(5);
        end_check(0, 0);

        // Test 6: reset after five loads of a long frame.
        cfg_interval = 4'd2;
        start_check();
        frame.delete();
        for (int i = 0; i < 10; i++) frame.push_back($urandom_range(0, 15));
        add_frame();
        send_all(0);
        n = 0;
        while (ld_x.size() - ld_base < 5 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("loads_before_reset", ld_x.size() - ld_base, 5);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("quiet_after_reset", m_valid | busy | x_load, 0);
        start_check();
        frame = '{2, 2, 2, 2};
        add_frame();
        send_all(0);
        end_check(2, 1);

        // Randomised frames, alternating single and back-to-back pairs.
        for (int r = 0; r < 4; r++) begin
            cfg_interval = 4'($urandom_range(0, 3));
            start_check();
            for (int f = 0; f <= r % 2; f++) begin
                frame.delete();
                n = $urandom_range(1, 9);
                for (int i = 0; i < n; i++) frame.push_back($urandom_range(0, 15));
                add_frame();
            end
            send_all(r % 2 == 0 ? 2 : 0);
            end_check(int'(cfg_interval), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/avg_feeder.md
Name: avg_feeder

Overview:
- Producer/consumer front end for the 4-tap moving-average block.
- Accepts 4-bit samples in frames over a valid/ready stream and buffers them in a small FIFO.
- Clears the averager at frame start and paces x_load strobes at a programmable interval.
- Inserts two zero flush loads at frame end, captures y at the correct pipeline slot, and emits only full-window averages (4Q2) with frame framing.

Parameters:
FIFO_DEPTH, 8, sample FIFO entries; power of 2, >= 2
INTERVAL_W, 4, width of cfg_interval

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_interval  in  INTERVAL_W  spacing between consecutive x_load pulses = cfg_interval+1 cycles
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready (= FIFO not full)
s_data  in  4  sample value
s_last  in  1  last sample of frame
avg_clr  out  1  one-cycle clear to averager (ORed with rst there)
x_load  out  1  load strobe to averager
x  out  4  sample to averager
y_in  in  6  averager output y
m_valid  out  1  output average valid (1-cycle pulse, no backpressure)
m_data  out  6  average, 4Q2 (sum of 4 samples)
m_last  out  1  with m_valid: last average of frame
err_short  out  1  1-cycle pulse: frame had fewer than 4 samples
busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous, active-high (rst) on clk:
  - All outputs 0; FIFO empty; state IDLE; counters 0.
  - Mid-frame reset abandons the frame, emits nothing further, and drops FIFO contents.
- FIFO, entries {last, data}:
  - Push when s_valid && s_ready; s_ready = !full (registered count).
  - Pop only in RUN on a load slot.
  - Push and pop in the same cycle are allowed when not full.
  - Empty: no pop. Full: s_ready=0.
- States:
  - IDLE: FIFO non-empty -> CLEAR.
  - CLEAR: avg_clr=1 for exactly 1 cycle; load index j=0; interval counter marked expired -> RUN.
  - RUN: on a load slot (counter expired) with FIFO non-empty:
    - Pop; x_load=1 and x=data for 1 cycle; reload counter with cfg_interval; j++.
    - If the popped entry has last=1 -> FLUSH with 2 loads pending.
  - RUN, counter expired but FIFO empty: stall; counter holds expired; no x_load.
  - FLUSH: issue 2 loads with x=0, spaced cfg_interval+1 cycles apart -> IDLE on the cycle after the second load.
- Timing and limits:
  - cfg_interval=0 gives x_load every cycle.
  - cfg_interval is sampled at each counter reload.
  - avg_clr and x_load are never high in the same cycle.
  - First load of a frame occurs the cycle after CLEAR.
- Averager timing: a load in cycle t with index j makes y_in hold the sum of samples j-2..j-5 in cycle t+1.
- Output capture:
  - y_in is registered in cycle t+1, so m_valid/m_data appear in cycle t+2.
  - Emit only when 5 <= j (j saturates at 5; no frame-length limit).
  - Frame of N samples (N >= 4) yields N-3 outputs; flush loads are j=N and j=N+1.
  - m_last=1 on the output from the second flush load.
- Short frame (N < 4): no m_valid. err_short pulses in cycle t+2 of the second flush load.
- x holds its last value when x_load=0; averager ignores it.
- m_data is an unsigned sum of four 4-bit samples, max 60, no overflow. No division is needed: the sum read as 4Q2 is the average.
- Back-to-back frames: the next frame's CLEAR follows the IDLE cycle. Samples may already be queued; the queued first sample waits in the FIFO.

Test Plan:
1. interval=0, frame {4,4,4,4 last} -> avg_clr once; 6 x_load pulses, x = 4,4,4,4,0,0; exactly one m_valid, m_data=16 (4.0), m_last=1.
2. interval=0, frame 0..7 (last on 7) -> 5 outputs m_data=6,10,14,18,22; m_last only on 22.
3. interval=2, frame {15 x6, last} -> x_load every 3 cycles; outputs 60,60,60; m_last on the third output.
4. Frame {3,5 last} -> 4 loads, no m_valid, single err_short pulse; next frame {1,1,1,1 last} -> single output 4 (clear prevents contamination).
5. interval=3, 12 samples pushed back-to-back with FIFO_DEPTH=8 -> s_ready drops when 8 entries are queued; no sample lost; 9 outputs in order; FIFO stall (s_valid gaps during RUN) delays x_load without output glitches.
6. rst asserted mid-RUN after 5 loads -> next cycle all outputs 0, busy=0, s_ready=1; new frame {2,2,2,2 last} -> single output 8.
